// File: rtl/io_responder.sv
// Memory-mapped I/O responder: LED register, debounced switches, scanned 8-digit
// seven-segment display, and an optional down-counting timer built only when IO_TIMER_EN is defined.
module io_responder #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SCAN_DIV        = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ior,
    input  logic        iow,
    input  logic [9:0]  addr_low,
    input  logic [31:0] wdata,
    input  logic [23:0] switch_in,
    output logic [31:0] rdata,
    output logic [23:0] led_out,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);

    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [9:0] OFF_SEG_DATA   = 10'h000;
    localparam logic [9:0] OFF_SEG_MASK   = 10'h004;
    localparam logic [9:0] OFF_TIMER      = 10'h020;
    localparam logic [9:0] OFF_TIMER_CTRL = 10'h024;
    localparam logic [9:0] OFF_LED        = 10'h060;
    localparam logic [9:0] OFF_SWITCH     = 10'h070;

    logic [9:0]  w_off;
    logic        w_unused;
    logic [31:0] w_timerRd;
    logic [31:0] w_ctrlRd;

    logic [23:0]       r_led;
    logic [31:0]       r_segData;
    logic [7:0]        r_segMask;
    logic [23:0]       r_sync1;
    logic [23:0]       r_sync2;
    logic [23:0]       r_capture;
    logic [23:0]       r_switch;
    logic [DEB_W-1:0]  r_debCnt;
    logic [SCAN_W-1:0] r_scanDiv;
    logic [2:0]        r_digit;

    assign w_off    = {addr_low[9:2], 2'b00};
    assign w_unused = ^addr_low[1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_led     <= '0;
            r_segData <= '0;
            r_segMask <= '0;
        end else if (iow) begin
            case (w_off)
                OFF_SEG_DATA: r_segData <= wdata;
                OFF_SEG_MASK: r_segMask <= wdata[7:0];
                OFF_LED:      r_led     <= wdata[23:0];
                default:      ;
            endcase
        end
    end

    // A new debounced value is accepted only when two captures one period apart agree.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_capture <= '0;
            r_switch  <= '0;
            r_debCnt  <= '0;
        end else begin
            r_sync1 <= switch_in;
            r_sync2 <= r_sync1;
            if (r_debCnt == DEB_LAST) begin
                r_debCnt  <= '0;
                r_capture <= r_sync2;
                if (r_sync2 == r_capture)
                    r_switch <= r_sync2;
            end else begin
                r_debCnt <= r_debCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_scanDiv <= '0;
            r_digit   <= '0;
        end else if (r_scanDiv == SCAN_LAST) begin
            r_scanDiv <= '0;
            r_digit   <= r_digit + 1'b1;
        end else begin
            r_scanDiv <= r_scanDiv + 1'b1;
        end
    end

`ifdef IO_TIMER_EN
    logic [31:0] r_tmrCount;
    logic [31:0] r_tmrReload;
    logic        r_tmrEn;
    logic        r_tmrFlag;
    logic        w_tmrExpire;
    logic        w_wrTimer;
    logic        w_wrCtrl;

    assign w_tmrExpire = r_tmrEn && (r_tmrCount == '0);
    assign w_wrTimer   = iow && (w_off == OFF_TIMER);
    assign w_wrCtrl    = iow && (w_off == OFF_TIMER_CTRL);

    // An expiry always sets the flag, even against a concurrent clear or count load.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tmrCount  <= '0;
            r_tmrReload <= '0;
            r_tmrEn     <= 1'b0;
            r_tmrFlag   <= 1'b0;
        end else begin
            if (w_wrTimer) begin
                r_tmrCount  <= wdata;
                r_tmrReload <= wdata;
            end else if (r_tmrEn) begin
                r_tmrCount <= w_tmrExpire ? r_tmrReload : r_tmrCount - 1'b1;
            end
            if (w_wrCtrl)
                r_tmrEn <= wdata[0];
            if (w_tmrExpire)
                r_tmrFlag <= 1'b1;
            else if (w_wrCtrl && wdata[1])
                r_tmrFlag <= 1'b0;
        end
    end

    assign w_timerRd = r_tmrCount;
    assign w_ctrlRd  = {30'd0, r_tmrFlag, r_tmrEn};
`else
    assign w_timerRd = '0;
    assign w_ctrlRd  = '0;
`endif

    always_comb begin
        rdata = '0;
        if (ior) begin
            case (w_off)
                OFF_SEG_DATA:   rdata = r_segData;
                OFF_SEG_MASK:   rdata = {24'd0, r_segMask};
                OFF_TIMER:      rdata = w_timerRd;
                OFF_TIMER_CTRL: rdata = w_ctrlRd;
                OFF_LED:        rdata = {8'd0, r_led};
                OFF_SWITCH:     rdata = {8'd0, r_switch};
                default:        rdata = '0;
            endcase
        end
    end

    logic [3:0] w_nibble;
    logic       w_digitOn;
    logic [6:0] w_segCode;

    assign w_nibble  = r_segData[{r_digit, 2'b00} +: 4];
    assign w_digitOn = r_segMask[r_digit];

    // Active-low {g..a} pattern for each hex value.
    always_comb begin
        w_segCode = 7'h7F;
        case (w_nibble)
            4'h0: w_segCode = 7'h40;
            4'h1: w_segCode = 7'h79;
            4'h2: w_segCode = 7'h24;
            4'h3: w_segCode = 7'h30;
            4'h4: w_segCode = 7'h19;
            4'h5: w_segCode = 7'h12;
            4'h6: w_segCode = 7'h02;
            4'h7: w_segCode = 7'h78;
            4'h8: w_segCode = 7'h00;
            4'h9: w_segCode = 7'h10;
            4'hA: w_segCode = 7'h08;
            4'hB: w_segCode = 7'h03;
            4'hC: w_segCode = 7'h46;
            4'hD: w_segCode = 7'h21;
            4'hE: w_segCode = 7'h06;
            4'hF: w_segCode = 7'h0E;
            default: w_segCode = 7'h7F;
        endcase
    end

    assign seg_an  = w_digitOn ? ~(8'b1 << r_digit) : 8'hFF;
    assign seg_out = w_digitOn ? {1'b1, w_segCode} : 8'hFF;
    assign led_out = r_led;

endmodule

// File: tb/tb_io_responder.sv
// Randomized scoreboard bench for io_responder: reads are predicted from a register-level
// model and checked by a monitor; display and LED outputs are checked directly.
module tb_io_responder;

    localparam int DEB  = 4;
    localparam int SDIV = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ior = 1'b0;
    logic        iow = 1'b0;
    logic [9:0]  addr_low = '0;
    logic [31:0] wdata = '0;
    logic [23:0] switch_in = '0;
    logic [31:0] rdata;
    logic [23:0] led_out;
    logic [7:0]  seg_an;
    logic [7:0]  seg_out;

    io_responder #(.DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SDIV)) dut (
        .clock(clock), .reset(reset), .ior(ior), .iow(iow), .addr_low(addr_low),
        .wdata(wdata), .switch_in(switch_in), .rdata(rdata), .led_out(led_out),
        .seg_an(seg_an), .seg_out(seg_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] exp;
    } readExp_t;

    readExp_t expQ[$];
    int total = 0;
    int bad = 0;
    int tbCyc = 0;

    logic [31:0] mSegData;
    logic [7:0]  mSegMask;
    logic [23:0] mLed;
    logic [23:0] mSwitch;
    logic [31:0] mCount;
    logic [31:0] mReload;
    logic        mEn;
    logic        mFlag;

    logic [7:0] hexTable [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Non-reset edges since the last reset, used to predict the scanned digit.
    always @(posedge clock) begin
        if (reset) tbCyc <= 0;
        else       tbCyc <= tbCyc + 1;
    end

    // Monitor: every cycle the DUT is read, the oldest prediction is compared.
    always @(negedge clock) begin
        if (ior) begin
            total = total + 1;
            if (expQ.size() == 0) begin
                bad = bad + 1;
                $display("[TB] FAIL rdata: unexpected read addr=%h actual=%h required=<none>", addr_low, rdata);
            end else begin
                readExp_t e;
                e = expQ.pop_front();
                if (rdata !== e.exp) begin
                    bad = bad + 1;
                    $display("[TB] FAIL rdata@%h: actual=%h required=%h", e.addr, rdata, e.exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] modelRead(input logic [9:0] a);
        logic [9:0] off;
        off = {a[9:2], 2'b00};
        case (off)
            10'h000: return mSegData;
            10'h004: return {24'd0, mSegMask};
            10'h060: return {8'd0, mLed};
            10'h070: return {8'd0, mSwitch};
`ifdef IO_TIMER_EN
            10'h020: return mCount;
            10'h024: return {30'd0, mFlag, mEn};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic modelReset();
        mSegData = '0; mSegMask = '0; mLed = '0; mSwitch = '0;
        mCount = '0; mReload = '0; mEn = 1'b0; mFlag = 1'b0;
    endtask

    task automatic modelEdge(input logic w, input logic [9:0] a, input logic [31:0] d);
        logic [9:0] off;
        logic expire;
        off = {a[9:2], 2'b00};
        expire = 1'b0;
`ifdef IO_TIMER_EN
        expire = mEn && (mCount == 0);
        if (mEn) mCount = expire ? mReload : mCount - 1;
        if (expire) mFlag = 1'b1;
`endif
        if (w) begin
            case (off)
                10'h000: mSegData = d;
                10'h004: mSegMask = d[7:0];
                10'h060: mLed = d[23:0];
`ifdef IO_TIMER_EN
                10'h020: begin mCount = d; mReload = d; end
                10'h024: begin
                    mEn = d[0];
                    if (d[1] && !expire) mFlag = 1'b0;
                end
`endif
                default: ;
            endcase
        end
    endtask

    // One bus cycle: drive strobes, predict any read, let the edge commit, update the model.
    task automatic applyStimulus(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d);
        ior = r; iow = w; addr_low = a; wdata = d;
        if (r) begin
            readExp_t e;
            e.addr = a;
            e.exp = modelRead(a);
            expQ.push_back(e);
        end
        @(posedge clock);
        #1;
        modelEdge(w, a, d);
        ior = 1'b0; iow = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 10'h000, 32'd0);
    endtask

    task automatic applyReset();
        reset = 1'b1; iow = 1'b1; addr_low = 10'h060; wdata = 32'hFFFF_FFFF;
        @(posedge clock);
        #1;
        reset = 1'b0; iow = 1'b0;
        modelReset();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        total = total + 1;
        if (actual !== required) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic checkSeg();
        int d;
        logic on;
        d = (tbCyc / SDIV) % 8;
        on = mSegMask[d];
        checkOutput("seg_an", {24'd0, seg_an}, on ? {24'd0, ~(8'd1 << d)} : 32'h0000_00FF);
        checkOutput("seg_out", {24'd0, seg_out}, on ? {24'd0, hexTable[mSegData[4*d +: 4]]} : 32'h0000_00FF);
    endtask

    task automatic settleSwitch(input logic [23:0] v);
        switch_in = v;
        idle(20);
        mSwitch = v;
    endtask

    initial begin
        logic [9:0] offs [7] = '{10'h000, 10'h004, 10'h020, 10'h024, 10'h060, 10'h070, 10'h3FC};
        #1;
        applyReset();
        applyReset();
        checkOutput("reset_led", {8'd0, led_out}, 32'd0);
        checkOutput("reset_seg_an", {24'd0, seg_an}, 32'h0000_00FF);
        checkOutput("reset_seg_out", {24'd0, seg_out}, 32'h0000_00FF);
        foreach (offs[i]) applyStimulus(1'b1, 1'b0, offs[i], 32'd0);

        applyStimulus(1'b0, 1'b1, 10'h060, 32'h12AB_CDEF);
        checkOutput("led_write", {8'd0, led_out}, 32'h00AB_CDEF);
        applyStimulus(1'b1, 1'b0, 10'h060, 32'd0);
        applyStimulus(1'b1, 1'b0, 10'h3FC, 32'd0);
        applyStimulus(1'b0, 1'b1, 10'h020, 32'd5);
        applyStimulus(1'b1, 1'b0, 10'h020, 32'd0);
        applyStimulus(1'b0, 1'b1, 10'h024, 32'd0);

        settleSwitch(24'h00F00F);
        applyStimulus(1'b1, 1'b0, 10'h070, 32'd0);
        switch_in = 24'hFFFFFF;
        idle(2);
        switch_in = 24'h00F00F;
        idle(20);
        applyStimulus(1'b1, 1'b0, 10'h070, 32'd0);
        for (int k = 0; k < 3; k++) begin
            settleSwitch(24'($urandom));
            applyStimulus(1'b1, 1'b0, 10'h071, 32'd0);
        end

        applyStimulus(1'b0, 1'b1, 10'h000, 32'h7654_3210);
        applyStimulus(1'b0, 1'b1, 10'h004, 32'h0000_0005);
        for (int k = 0; k < 20; k++) begin
            checkSeg();
            idle(1);
        end
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1'b0, 1'b1, 10'h000, $urandom);
            applyStimulus(1'b0, 1'b1, 10'h004, $urandom);
            for (int k = 0; k < 16; k++) begin
                checkSeg();
                idle(1);
            end
        end

`ifdef IO_TIMER_EN
        applyStimulus(1'b0, 1'b1, 10'h020, 32'd3);
        applyStimulus(1'b0, 1'b1, 10'h024, 32'd1);
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, 10'h024, 32'd0);
        applyStimulus(1'b1, 1'b0, 10'h020, 32'd0);
        applyStimulus(1'b0, 1'b1, 10'h024, 32'd3);
        for (int k = 0; k < 8 && mCount != 0; k++) applyStimulus(1'b1, 1'b0, 10'h020, 32'd0);
        applyStimulus(1'b1, 1'b1, 10'h024, 32'd3);
        applyStimulus(1'b1, 1'b0, 10'h024, 32'd0);
        applyStimulus(1'b1, 1'b0, 10'h020, 32'd0);
        applyStimulus(1'b0, 1'b1, 10'h024, 32'd3);
        for (int k = 0; k < 8 && mCount != 0; k++) applyStimulus(1'b1, 1'b0, 10'h020, 32'd0);
        applyStimulus(1'b1, 1'b1, 10'h020, 32'd7);
        applyStimulus(1'b1, 1'b0, 10'h020, 32'd0);
        applyStimulus(1'b1, 1'b0, 10'h024, 32'd0);
        applyStimulus(1'b1, 1'b0, 10'h020, 32'd0);
`endif

        for (int k = 0; k < 400; k++) begin
            logic [9:0] a;
            logic [31:0] d;
            a = offs[$urandom_range(0, 6)] | 10'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = 10'($urandom);
            d = $urandom;
`ifdef IO_TIMER_EN
            if ({a[9:2], 2'b00} == 10'h020) d = 32'($urandom_range(0, 12));
`endif
            applyStimulus(1'($urandom), 1'($urandom), a, d);
            if (k % 50 == 0) checkOutput("led_rand", {8'd0, led_out}, {8'd0, mLed});
        end

        applyReset();
        checkOutput("reset2_led", {8'd0, led_out}, 32'd0);
        checkOutput("reset2_seg_an", {24'd0, seg_an}, 32'h0000_00FF);
        foreach (offs[i]) applyStimulus(1'b1, 1'b0, offs[i], 32'd0);

        idle(2);
        if (expQ.size() != 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("[TB] FAIL drain: actual=%0d required=0 pending reads", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
